sccb_cfg_sequencer: RTL and testbench
=====================================

# sccb_cfg_sequencer

Boot-time register loader and bus owner for the SCCB bridge. After reset, or on request, it walks a configuration table held in an external synchronous ROM and issues one SCCB write per entry through the bridge's command port. Special entries insert programmable delays or end the table. Once loading finishes, the bridge port passes straight through to a host requester; the block arbitrates bridge ownership between the internal loader and the host.

## Interface
- SCCB_ID, 7'h21, 7-bit device ID driven on maddr[14:8]
- TBL_AW, 6, table address width (table depth 2^TBL_AW)
- DELAY_SHIFT, 12, delay unit = 2^DELAY_SHIFT sccb_clk cycles
- TIMEOUT, 20'hFFFFF, watchdog limit in sccb_clk cycles per entry
- sccb_clk  in  1  clock
- sccb_reset_n  in  1  asynchronous, active-low reset
- init_start  in  1  pulse; rerun the table
- init_busy  out  1  loader owns the bridge
- init_done  out  1  last load reached its end marker without error
- init_err  out  1  last load aborted on watchdog timeout
- tbl_addr  out  TBL_AW  ROM address
- tbl_data  in  16  ROM data {reg[15:8], val[7:0]}, valid one cycle after tbl_addr
- mcmd / maddr / mdata  out  3/15/8  to bridge
- scmdaccept  in  1  bridge idle
- sresp / sdata  in  2/8  from bridge
- host_cmd / host_addr / host_wdata  in  3/15/8  host request (3'b001 = write, 3'b010 = read, 3'b000 = idle)
- host_accept  out  1  equals scmdaccept in host mode, else 0
- host_resp / host_rdata  out  2/8  equal sresp/sdata in host mode, else 0

## Operation
- States: FETCH, DECODE, ISSUE, BUSY, DELAY, HOST, DRAIN.
- Reset values:
  - State FETCH, tbl_addr 0.
  - mcmd, maddr and mdata all 0.
  - host_accept, host_resp and host_rdata all 0.
  - init_busy 1, init_done 0, init_err 0.
- The load starts automatically when reset is released.
- FETCH: present tbl_addr; go to DECODE next cycle.
- DECODE: register tbl_data, then branch:
  - 16'hFFFF: end marker. Go to HOST; init_done=1.
  - reg==8'hFE: delay entry. Load delay counter with {val, DELAY_SHIFT'b0}. Go to DELAY; if val==0, go straight to the next entry.
  - Any other value: go to ISSUE.
- ISSUE: drive mcmd=3'b001, maddr={SCCB_ID, reg}, mdata=val. Hold them until scmdaccept is sampled 0, then drive mcmd=0 and go to BUSY.
- BUSY: wait for scmdaccept==1, then advance to the next entry.
- DELAY: decrement the counter to 0, then advance to the next entry.
- Advance to next entry:
  - If tbl_addr==2^TBL_AW-1, treat it as the end marker (wrap is not allowed).
  - Otherwise increment tbl_addr and go to FETCH.
- Watchdog:
  - Counts sccb_clk cycles while in ISSUE or BUSY; cleared on entering ISSUE.
  - Reaching TIMEOUT: init_err=1, init_done=0, mcmd=0, go to HOST.
- HOST: bridge outputs combinationally equal the host inputs. init_busy=0.
- init_start:
  - In HOST it sets a pending flag.
  - While pending, host_accept is forced to 0. DRAIN is entered in the first cycle with scmdaccept==1 and host_cmd==3'b000, so an in-flight host transfer is never cut.
  - DRAIN: mcmd=0; the next cycle clears init_done/init_err, sets tbl_addr=0 and init_busy=1, and goes to FETCH.
  - init_start outside HOST is ignored; the pending flag is not set.
- The loader never issues reads. Read responses (sresp==2'b01 with sdata) are only forwarded in HOST.

## Timing
- All state is on sccb_clk; no gated clocks in this block.
- ROM latency: exactly 1 cycle (FETCH→DECODE).
- Minimum per write entry: FETCH + DECODE + ISSUE hold (bridge-dependent) + BUSY.
- The mcmd hold is mandatory. The bridge recaptures mcmd every cycle while idle, and its FSM only advances on its divided clock enable.
- A delay entry with val=N lasts N·2^DELAY_SHIFT cycles in DELAY, plus 2 cycles for fetch/decode.
- The HOST passthrough adds no latency.
- Mid-operation reset: outputs return to reset values immediately and the load restarts from entry 0.

## Structure
- Shared package sccb_pkg: bridge command encodings (IDLE/WR/RD), DVA response 2'b01, table markers 8'hFE and 16'hFFFF, state encoding.
- Sub-module sccb_cfg_delay: loadable down-counter with a done flag, reused for both delay and watchdog.
- The ROM is external (sccb_cfg_rom), so table contents change without touching this block.

## Test plan
- Table {12'80 → 0x1280, 0xFFFF}, bridge model with 40-cycle busy: one write, maddr=15'h2112, mdata=0x80, then init_done=1 and init_busy=0.
- Table {0xFE02, 0x1104, 0xFFFF}, DELAY_SHIFT=4: mcmd=3'b001 first asserted ≥32 cycles after the delay entry decodes.
- Bridge model that never deasserts scmdaccept, TIMEOUT=100: init_err=1 at cycle 100 of ISSUE, mcmd=0, HOST entered.
- Table with no end marker, TBL_AW=2: exactly 4 writes, then init_done=1 and tbl_addr stays 3.
- HOST read 15'h210A, bridge returns 0x5A: host_resp=2'b01, host_rdata=0x5A. init_start asserted mid-read leaves the read intact; DRAIN only after host_cmd=0 and scmdaccept=1.
- Reset asserted during BUSY of entry 2: mcmd=0 and tbl_addr=0 immediately; after release, entry 0 reissued.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB bridge and its configuration sequencer:
// bridge command/response encodings, table markers and sequencer states.
package sccb_pkg;

  localparam logic [2:0]  CMD_IDLE = 3'b000;
  localparam logic [2:0]  CMD_WR   = 3'b001;
  localparam logic [2:0]  CMD_RD   = 3'b010;

  localparam logic [1:0]  RESP_DVA = 2'b01;

  localparam logic [7:0]  TBL_DELAY_REG = 8'hFE;
  localparam logic [15:0] TBL_END       = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_BUSY,
    ST_DELAY,
    ST_HOST,
    ST_DRAIN
  } cfg_state_e;

  function automatic logic is_end_entry(input logic [15:0] entry);
    return entry == TBL_END;
  endfunction

  function automatic logic is_delay_entry(input logic [15:0] entry);
    return entry[15:8] == TBL_DELAY_REG;
  endfunction

endpackage

// File: rtl/sccb_cfg_delay.sv
// Loadable down-counter. 'last' flags the final counted cycle, so a load of N
// with 'en' held high yields exactly N enabled cycles up to and including 'last'.
module sccb_cfg_delay #(
  parameter int W = 20
) (
  input  logic         sccb_clk,
  input  logic         sccb_reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge sccb_clk or negedge sccb_reset_n) begin
    if (!sccb_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == W'(1));

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// Boot-time SCCB register loader: walks an external ROM table, issues one bridge
// write per entry, then arbitrates the bridge port over to the host requester.
module sccb_cfg_sequencer
  import sccb_pkg::*;
#(
  parameter logic [6:0]  SCCB_ID     = 7'h21,
  parameter int          TBL_AW      = 6,
  parameter int          DELAY_SHIFT = 12,
  parameter logic [19:0] TIMEOUT     = 20'hFFFFF
) (
  input  logic              sccb_clk,
  input  logic              sccb_reset_n,
  input  logic              init_start,
  output logic              init_busy,
  output logic              init_done,
  output logic              init_err,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  output logic [2:0]        mcmd,
  output logic [14:0]       maddr,
  output logic [7:0]        mdata,
  input  logic              scmdaccept,
  input  logic [1:0]        sresp,
  input  logic [7:0]        sdata,
  input  logic [2:0]        host_cmd,
  input  logic [14:0]       host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_accept,
  output logic [1:0]        host_resp,
  output logic [7:0]        host_rdata
);

  localparam int DLY_W = 8 + DELAY_SHIFT;

  cfg_state_e        state_q, state_d;
  logic [TBL_AW-1:0] tbl_addr_q, tbl_addr_d;
  logic [7:0]        reg_q, reg_d;
  logic [7:0]        val_q, val_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              pending_q, pending_d;

  logic              dly_load;
  logic              dly_last;
  logic              wdg_load;
  logic              wdg_last;
  logic              advance;

  sccb_cfg_delay #(.W(DLY_W)) u_delay (
    .sccb_clk     (sccb_clk),
    .sccb_reset_n (sccb_reset_n),
    .load         (dly_load),
    .load_val     ({tbl_data[7:0], {DELAY_SHIFT{1'b0}}}),
    .en           (state_q == ST_DELAY),
    .last         (dly_last)
  );

  // Watchdog spans the whole write handshake: command hold plus bridge busy.
  sccb_cfg_delay #(.W(20)) u_watchdog (
    .sccb_clk     (sccb_clk),
    .sccb_reset_n (sccb_reset_n),
    .load         (wdg_load),
    .load_val     (TIMEOUT),
    .en           ((state_q == ST_ISSUE) || (state_q == ST_BUSY)),
    .last         (wdg_last)
  );

  always_comb begin
    state_d    = state_q;
    tbl_addr_d = tbl_addr_q;
    reg_d      = reg_q;
    val_d      = val_q;
    done_d     = done_q;
    err_d      = err_q;
    pending_d  = pending_q;
    dly_load   = 1'b0;
    wdg_load   = 1'b0;
    advance    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        reg_d = tbl_data[15:8];
        val_d = tbl_data[7:0];
        if (is_end_entry(tbl_data)) begin
          state_d = ST_HOST;
          done_d  = 1'b1;
        end else if (is_delay_entry(tbl_data)) begin
          if (tbl_data[7:0] == 8'd0) begin
            advance = 1'b1;
          end else begin
            dly_load = 1'b1;
            state_d  = ST_DELAY;
          end
        end else begin
          wdg_load = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      // The bridge only drops scmdaccept once it has captured the command.
      ST_ISSUE: begin
        if (!scmdaccept) begin
          state_d = ST_BUSY;
        end else if (wdg_last) begin
          state_d = ST_HOST;
          err_d   = 1'b1;
          done_d  = 1'b0;
        end
      end
      ST_BUSY: begin
        if (scmdaccept) begin
          advance = 1'b1;
        end else if (wdg_last) begin
          state_d = ST_HOST;
          err_d   = 1'b1;
          done_d  = 1'b0;
        end
      end
      ST_DELAY: begin
        if (dly_last) begin
          advance = 1'b1;
        end
      end
      // A rerun waits for the host to go quiet so a transfer is never cut.
      ST_HOST: begin
        if (init_start) begin
          pending_d = 1'b1;
        end
        if (pending_q && scmdaccept && (host_cmd == CMD_IDLE)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d    = ST_FETCH;
        tbl_addr_d = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        pending_d  = 1'b0;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    if (advance) begin
      if (&tbl_addr_q) begin
        state_d = ST_HOST;
        done_d  = 1'b1;
      end else begin
        tbl_addr_d = tbl_addr_q + TBL_AW'(1);
        state_d    = ST_FETCH;
      end
    end
  end

  always_ff @(posedge sccb_clk or negedge sccb_reset_n) begin
    if (!sccb_reset_n) begin
      state_q    <= ST_FETCH;
      tbl_addr_q <= '0;
      reg_q      <= '0;
      val_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tbl_addr_q <= tbl_addr_d;
      reg_q      <= reg_d;
      val_q      <= val_d;
      done_q     <= done_d;
      err_q      <= err_d;
      pending_q  <= pending_d;
    end
  end

  // Bridge port mux: loader write in ISSUE, zero-latency host passthrough in HOST.
  always_comb begin
    mcmd        = CMD_IDLE;
    maddr       = '0;
    mdata       = '0;
    host_accept = 1'b0;
    host_resp   = '0;
    host_rdata  = '0;
    case (state_q)
      ST_ISSUE: begin
        mcmd  = CMD_WR;
        maddr = {SCCB_ID, reg_q};
        mdata = val_q;
      end
      ST_HOST: begin
        mcmd        = host_cmd;
        maddr       = host_addr;
        mdata       = host_wdata;
        host_accept = scmdaccept & ~pending_q;
        host_resp   = sresp;
        host_rdata  = sdata;
      end
      default: begin
      end
    endcase
  end

  assign init_busy = (state_q != ST_HOST) && (state_q != ST_DRAIN);
  assign init_done = done_q;
  assign init_err  = err_q;
  assign tbl_addr  = tbl_addr_q;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Bench for sccb_cfg_sequencer: synchronous ROM and busy-counting bridge models,
// with expected write sequences derived from the table contents.
module tb_sccb_cfg_sequencer;
  import sccb_pkg::*;

  localparam int          AW    = 2;
  localparam int          DEPTH = 4;
  localparam int          DS    = 4;
  localparam logic [19:0] TO    = 20'd100;
  localparam logic [6:0]  ID    = 7'h21;

  logic          sccb_clk = 1'b0;
  logic          sccb_reset_n = 1'b0;
  logic          init_start = 1'b0;
  logic          init_busy, init_done, init_err;
  logic [AW-1:0] tbl_addr;
  logic [15:0]   tbl_data;
  logic [2:0]    mcmd;
  logic [14:0]   maddr;
  logic [7:0]    mdata;
  logic          scmdaccept;
  logic [1:0]    sresp;
  logic [7:0]    sdata;
  logic [2:0]    host_cmd = 3'b000;
  logic [14:0]   host_addr = '0;
  logic [7:0]    host_wdata = '0;
  logic          host_accept;
  logic [1:0]    host_resp;
  logic [7:0]    host_rdata;

  int checks = 0;
  int errors = 0;

  sccb_cfg_sequencer #(
    .SCCB_ID(ID), .TBL_AW(AW), .DELAY_SHIFT(DS), .TIMEOUT(TO)
  ) dut (
    .sccb_clk(sccb_clk), .sccb_reset_n(sccb_reset_n), .init_start(init_start),
    .init_busy(init_busy), .init_done(init_done), .init_err(init_err),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .mcmd(mcmd), .maddr(maddr), .mdata(mdata),
    .scmdaccept(scmdaccept), .sresp(sresp), .sdata(sdata),
    .host_cmd(host_cmd), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_accept(host_accept), .host_resp(host_resp), .host_rdata(host_rdata)
  );

  always #5 sccb_clk = ~sccb_clk;

  // Synchronous ROM, one cycle of read latency
  logic [15:0] rom [DEPTH];
  always @(posedge sccb_clk) tbl_data <= rom[tbl_addr];

  // Bridge model: captures a command while idle, then stays busy br_busy cycles
  // (random 1..60 when br_busy is 0); reads return br_rdata with DVA on completion.
  int          br_busy = 40;
  bit          br_stuck = 1'b0;
  logic [7:0]  br_rdata = 8'h00;
  int          busy_cnt;
  bit          rd_pend;
  logic [25:0] log_q[$];
  logic [22:0] exp_q[$];

  always @(posedge sccb_clk or negedge sccb_reset_n) begin
    if (!sccb_reset_n) begin
      scmdaccept <= 1'b1;
      sresp      <= 2'b00;
      sdata      <= 8'h00;
      busy_cnt   <= 0;
      rd_pend    <= 1'b0;
    end else begin
      sresp <= 2'b00;
      if (scmdaccept) begin
        if (mcmd != CMD_IDLE && !br_stuck) begin
          scmdaccept <= 1'b0;
          busy_cnt   <= (br_busy != 0) ? br_busy : int'($urandom_range(1, 60));
          rd_pend    <= (mcmd == CMD_RD);
          log_q.push_back({mcmd, maddr, mdata});
        end
      end else if (busy_cnt > 1) begin
        busy_cnt <= busy_cnt - 1;
      end else begin
        scmdaccept <= 1'b1;
        if (rd_pend) begin
          sresp <= RESP_DVA;
          sdata <= br_rdata;
        end
      end
    end
  end

  // Reference: the writes a complete table walk must produce, and where it stops
  function automatic int model_load();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      if (rom[i] == 16'hFFFF) return i;
      if (rom[i][15:8] != 8'hFE) exp_q.push_back({ID, rom[i]});
    end
    return DEPTH - 1;
  endfunction

  task automatic fill_random(input bit allow_special);
    for (int i = 0; i < DEPTH; i++) begin
      int unsigned r = $urandom_range(0, 9);
      if (!allow_special || r < 6) rom[i] = {8'($urandom_range(0, 253)), 8'($urandom)};
      else if (r < 8)              rom[i] = {8'hFE, 8'($urandom_range(0, 2))};
      else                         rom[i] = 16'hFFFF;
    end
  endtask

  // Pulse init_start from HOST and wait for the reload to start and finish
  task automatic run_load(output bit ok);
    init_start = 1'b1;
    @(negedge sccb_clk);
    init_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (init_busy) begin ok = 1'b1; break; end
      @(negedge sccb_clk);
    end
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
        @(negedge sccb_clk);
        if (!init_busy) begin ok = 1'b1; break; end
      end
    end
  endtask

  task automatic test_reset();
    rom[0] = 16'h1280; rom[1] = 16'hFFFF; rom[2] = 16'h0000; rom[3] = 16'h0000;
    sccb_reset_n = 1'b0;
    repeat (3) @(negedge sccb_clk);
    checks++; if (mcmd !== 3'b000) begin errors++; $display("FAIL reset_mcmd got %h exp 0", mcmd); end
    checks++; if (maddr !== 15'h0) begin errors++; $display("FAIL reset_maddr got %h exp 0", maddr); end
    checks++; if (mdata !== 8'h0) begin errors++; $display("FAIL reset_mdata got %h exp 0", mdata); end
    checks++; if (tbl_addr !== 2'd0) begin errors++; $display("FAIL reset_tbl_addr got %h exp 0", tbl_addr); end
    checks++; if ({host_accept, host_resp, host_rdata} !== 11'h0) begin
      errors++; $display("FAIL reset_host got %h/%h/%h exp 0/0/0", host_accept, host_resp, host_rdata);
    end
    checks++; if ({init_busy, init_done, init_err} !== 3'b100) begin
      errors++; $display("FAIL reset_flags got busy/done/err %b exp 100", {init_busy, init_done, init_err});
    end
  endtask

  task automatic test_single_write();
    bit ok;
    log_q.delete();
    br_busy = 40;
    sccb_reset_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge sccb_clk);
      if (!init_busy) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got busy exp idle"); end
    checks++; if (log_q.size() != 1) begin errors++; $display("FAIL single_count got %0d exp 1", log_q.size()); end
    else begin
      checks++; if (log_q[0] !== {CMD_WR, 15'h2112, 8'h80}) begin
        errors++; $display("FAIL single_write got %h exp %h", log_q[0], {CMD_WR, 15'h2112, 8'h80});
      end
    end
    checks++; if ({init_done, init_err, init_busy} !== 3'b100) begin
      errors++; $display("FAIL single_flags got done/err/busy %b exp 100", {init_done, init_err, init_busy});
    end
  endtask

  task automatic test_delay();
    int n, t;
    bit started, ok, ok2;
    n = $urandom_range(1, 3);
    rom[0] = {8'hFE, 8'(n)}; rom[1] = 16'h1104; rom[2] = 16'hFFFF; rom[3] = 16'h0000;
    log_q.delete();
    br_busy = 5;
    init_start = 1'b1;
    @(negedge sccb_clk);
    init_start = 1'b0;
    started = 1'b0; ok = 1'b0; t = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sccb_clk);
      if (started) t++;
      else if (init_busy) started = 1'b1;
      if (started && mcmd == CMD_WR) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL delay_no_issue got none exp write"); end
    // fetch+decode of the delay entry, N*16 delay cycles, fetch+decode of the write
    checks++; if (t != 4 + n * 16) begin errors++; $display("FAIL delay_latency got %0d exp %0d", t, 4 + n * 16); end
    ok2 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sccb_clk);
      if (!init_busy) begin ok2 = 1'b1; break; end
    end
    checks++; if (!ok2 || log_q.size() != 1 || log_q[0] !== {CMD_WR, 15'h2111, 8'h04}) begin
      errors++; $display("FAIL delay_write got %0d writes first %h exp 1 write %h",
                         log_q.size(), (log_q.size() > 0) ? log_q[0] : 26'h0, {CMD_WR, 15'h2111, 8'h04});
    end
  endtask

  task automatic test_timeout();
    int n;
    bit seen, ok;
    rom[0] = {8'($urandom_range(0, 253)), 8'($urandom)}; rom[1] = 16'hFFFF;
    log_q.delete();
    br_stuck = 1'b1;
    init_start = 1'b1;
    @(negedge sccb_clk);
    init_start = 1'b0;
    seen = 1'b0; ok = 1'b0; n = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge sccb_clk);
      if (init_busy) seen = 1'b1;
      if (mcmd == CMD_WR) n++;
      if (seen && !init_busy) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL timeout_hang got busy exp host"); end
    checks++; if (n != int'(TO)) begin errors++; $display("FAIL timeout_issue_cycles got %0d exp %0d", n, TO); end
    checks++; if ({init_err, init_done, mcmd} !== 5'b10_000) begin
      errors++; $display("FAIL timeout_flags got err/done/mcmd %b %b %h exp 1 0 0", init_err, init_done, mcmd);
    end
    br_stuck = 1'b0;
  endtask

  task automatic test_no_end_marker();
    bit ok;
    int exp_end;
    fill_random(1'b0);
    exp_end = model_load();
    log_q.delete();
    br_busy = 0;
    run_load(ok);
    checks++; if (!ok) begin errors++; $display("FAIL noend_hang got busy exp done"); end
    checks++; if (log_q.size() != 4) begin errors++; $display("FAIL noend_count got %0d exp 4", log_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (log_q[i] !== {CMD_WR, exp_q[i]}) begin
        errors++; $display("FAIL noend_write%0d got %h exp %h", i, log_q[i], {CMD_WR, exp_q[i]});
      end
    end
    repeat (5) @(negedge sccb_clk);
    checks++; if (tbl_addr !== 2'(exp_end) || init_done !== 1'b1 || init_err !== 1'b0) begin
      errors++; $display("FAIL noend_final got addr %0d done %b err %b exp 3 1 0", tbl_addr, init_done, init_err);
    end
  endtask

  task automatic test_random_tables();
    bit ok;
    int exp_end;
    for (int it = 0; it < 4; it++) begin
      fill_random(1'b1);
      exp_end = model_load();
      log_q.delete();
      br_busy = 0;
      run_load(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_hang got busy exp done", it); end
      checks++; if (log_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand%0d_count got %0d exp %0d", it, log_q.size(), exp_q.size());
      end else for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (log_q[i] !== {CMD_WR, exp_q[i]}) begin
          errors++; $display("FAIL rand%0d_write%0d got %h exp %h", it, i, log_q[i], {CMD_WR, exp_q[i]});
        end
      end
      checks++; if (tbl_addr !== 2'(exp_end) || init_done !== 1'b1 || init_err !== 1'b0) begin
        errors++; $display("FAIL rand%0d_final got addr %0d done %b err %b exp %0d 1 0",
                           it, tbl_addr, init_done, init_err, exp_end);
      end
    end
  endtask

  task automatic test_host_read();
    bit ok;
    logic [7:0] rd;
    rom[0] = 16'h1280; rom[1] = 16'hFFFF;
    br_busy = 20;
    log_q.delete();
    checks++; if (host_accept !== 1'b1 || host_resp !== 2'b00) begin
      errors++; $display("FAIL host_idle got accept %b resp %b exp 1 00", host_accept, host_resp);
    end
    host_cmd = CMD_RD; host_addr = 15'h210A; host_wdata = 8'h00; br_rdata = 8'h5A;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sccb_clk);
      if (!host_accept) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL host_accept_drop got 1 exp 0"); end
    host_cmd = CMD_IDLE;
    init_start = 1'b1;
    @(negedge sccb_clk);
    init_start = 1'b0;
    checks++; if (init_busy !== 1'b0) begin errors++; $display("FAIL host_cut_read got busy %b exp 0", init_busy); end
    ok = 1'b0; rd = 8'h00;
    for (int i = 0; i < 60; i++) begin
      if (host_resp === RESP_DVA) begin ok = 1'b1; rd = host_rdata; break; end
      @(negedge sccb_clk);
    end
    checks++; if (!ok || rd !== 8'h5A) begin
      errors++; $display("FAIL host_read_data got resp_seen %b data %h exp 1 5a", ok, rd);
    end
    checks++; if (host_accept !== 1'b0 || init_busy !== 1'b0) begin
      errors++; $display("FAIL host_pending got accept %b busy %b exp 0 0", host_accept, init_busy);
    end
    checks++; if (log_q.size() != 1 || log_q[0] !== {CMD_RD, 15'h210A, 8'h00}) begin
      errors++; $display("FAIL host_read_cmd got %0d cmds first %h exp 1 %h",
                         log_q.size(), (log_q.size() > 0) ? log_q[0] : 26'h0, {CMD_RD, 15'h210A, 8'h00});
    end
    @(negedge sccb_clk);
    checks++; if (init_busy !== 1'b0 || mcmd !== CMD_IDLE || host_resp !== 2'b00) begin
      errors++; $display("FAIL host_drain got busy %b mcmd %h resp %b exp 0 0 00", init_busy, mcmd, host_resp);
    end
    @(negedge sccb_clk);
    checks++; if (init_busy !== 1'b1 || init_done !== 1'b0 || tbl_addr !== 2'd0) begin
      errors++; $display("FAIL host_restart got busy %b done %b addr %0d exp 1 0 0", init_busy, init_done, tbl_addr);
    end
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge sccb_clk);
      if (!init_busy) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || init_done !== 1'b1) begin errors++; $display("FAIL host_reload got done %b exp 1", init_done); end
  endtask

  task automatic test_reset_mid_busy();
    bit ok;
    fill_random(1'b0);
    void'(model_load());
    br_busy = 40;
    init_start = 1'b1;
    @(negedge sccb_clk);
    init_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge sccb_clk);
      if (init_busy && tbl_addr == 2'd2 && mcmd == CMD_IDLE && !scmdaccept) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rst_reach_busy got none exp entry2 busy"); end
    sccb_reset_n = 1'b0;
    #1;
    checks++; if (mcmd !== CMD_IDLE || tbl_addr !== 2'd0 || init_busy !== 1'b1) begin
      errors++; $display("FAIL rst_immediate got mcmd %h addr %0d busy %b exp 0 0 1", mcmd, tbl_addr, init_busy);
    end
    @(negedge sccb_clk);
    log_q.delete();
    sccb_reset_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge sccb_clk);
      if (!init_busy) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || log_q.size() != 4) begin
      errors++; $display("FAIL rst_reload got done %b writes %0d exp 1 4", ok, log_q.size());
    end else for (int i = 0; i < 4; i++) begin
      checks++; if (log_q[i] !== {CMD_WR, exp_q[i]}) begin
        errors++; $display("FAIL rst_write%0d got %h exp %h", i, log_q[i], {CMD_WR, exp_q[i]});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_delay();
    test_timeout();
    test_no_end_marker();
    test_random_tables();
    test_host_read();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
